dsi_tx_line_buffer: RTL and testbench

Single-clock, parametrised pixel line buffer between the pixel source (Avalon-ST) and the DSI packetiser, in the system clock domain.
- Stores data words together with SOP/EOP sideband bits.
- Counts complete lines held, and raises line-ready on either a full line or a fill threshold.
- Applies registered backpressure with a configurable margin.
- Flags overflow and underflow with sticky error bits.
- Replaces the dual-clock vendor-FIFO buffer with an inferred, width/depth-generic memory.

---
 rtl/dsi_tx_line_buffer_if.sv | 60 ++++++
 rtl/dsi_tx_line_buffer.sv | 180 ++++++++++++++++++
 tb/tb_dsi_tx_line_buffer.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dsi_tx_line_buffer_if.sv
// dsi_tx_line_buffer_if
//   Groups the pixel-source (Avalon-ST sink) handshake, the packetiser-side
//   show-ahead read port, and the status/error signals of the line buffer.
//
//   Modports:
//     slave  - the line buffer itself (accepts pixels, serves the packetiser)
//     master - the environment (pixel source + packetiser + status reader)
//
//   Signals:
//     avl_st_in_data/valid/startofpacket/endofpacket  source -> buffer
//     avl_st_in_ready                                 buffer -> source
//     fifo_data/sop/eop/not_empty/line_ready          buffer -> packetiser
//     fifo_read_ack                                   packetiser -> buffer
//     fifo_usedw, lines_stored                        fill status
//     overflow_err, underflow_err, err_clear          sticky error flags
//     stat_max_usedw, stat_lines_total                optional statistics
interface dsi_tx_line_buffer_if #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 1024
);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] avl_st_in_data;
    logic                  avl_st_in_valid;
    logic                  avl_st_in_startofpacket;
    logic                  avl_st_in_endofpacket;
    logic                  avl_st_in_ready;

    logic [DATA_WIDTH-1:0] fifo_data;
    logic                  fifo_sop;
    logic                  fifo_eop;
    logic                  fifo_not_empty;
    logic                  fifo_line_ready;
    logic                  fifo_read_ack;
    logic [AW:0]           fifo_usedw;
    logic [AW:0]           lines_stored;

    logic                  overflow_err;
    logic                  underflow_err;
    logic                  err_clear;

    logic [AW:0]           stat_max_usedw;
    logic [31:0]           stat_lines_total;

    modport slave (
        input  avl_st_in_data, avl_st_in_valid, avl_st_in_startofpacket,
               avl_st_in_endofpacket, fifo_read_ack, err_clear,
        output avl_st_in_ready, fifo_data, fifo_sop, fifo_eop, fifo_not_empty,
               fifo_line_ready, fifo_usedw, lines_stored, overflow_err,
               underflow_err, stat_max_usedw, stat_lines_total
    );

    modport master (
        output avl_st_in_data, avl_st_in_valid, avl_st_in_startofpacket,
               avl_st_in_endofpacket, fifo_read_ack, err_clear,
        input  avl_st_in_ready, fifo_data, fifo_sop, fifo_eop, fifo_not_empty,
               fifo_line_ready, fifo_usedw, lines_stored, overflow_err,
               underflow_err, stat_max_usedw, stat_lines_total
    );
endinterface

// File: rtl/dsi_tx_line_buffer.sv
// dsi_tx_line_buffer
//   Single-clock pixel line buffer between the Avalon-ST pixel source and the
//   DSI packetiser. Words are stored with their SOP/EOP bits in an inferred
//   synchronous RAM; a head register in front of the RAM gives a show-ahead
//   read port. Tracks fill level and complete lines, raises line-ready on a
//   complete line or a fill threshold, drives registered backpressure and
//   keeps sticky overflow/underflow flags.
//
//   Ports:
//     clk    system clock
//     rst_n  asynchronous active-low reset (discards all contents)
//     bus    dsi_tx_line_buffer_if.slave (see interface file for signals)
//
//   Build option:
//     DSI_TX_LINE_BUF_STATS_EN - when defined, builds the peak-fill and
//     popped-line statistics counters; otherwise those outputs are tied to 0.
module dsi_tx_line_buffer #(
    parameter int DATA_WIDTH     = 32,
    parameter int FIFO_DEPTH     = 1024,
    parameter int LINE_THRESHOLD = 640,
    parameter int FULL_MARGIN    = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    dsi_tx_line_buffer_if.slave     bus
);
    localparam int AW        = $clog2(FIFO_DEPTH);
    localparam int MW        = DATA_WIDTH + 2;
    localparam int THR_WORDS = LINE_THRESHOLD / (DATA_WIDTH / 8);

    localparam logic [AW:0]   DEPTH_W     = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0]   READY_LIMIT = (AW+1)'(FIFO_DEPTH - FULL_MARGIN);
    localparam logic [AW:0]   CNT_ONE     = {{AW{1'b0}}, 1'b1};
    localparam logic [AW-1:0] PTR_ONE     = {{(AW-1){1'b0}}, 1'b1};

    // Memory word layout: {eop, sop, data}
    logic [MW-1:0]   mem [FIFO_DEPTH];

    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     usedw_q, usedw_d;
    logic [AW:0]     lines_q, lines_d;
    logic            head_valid_q, head_valid_d;
    logic [MW-1:0]   head_q;
    logic            ready_q;
    logic            line_ready_q;
    logic            ovf_q;
    logic            unf_q;

    logic            pop;
    logic            full;
    logic            wr_en;
    logic            ovf_set;
    logic            unf_set;
    logic            head_load;
    logic            wr_eop;
    logic            pop_eop;
    logic [AW:0]     mem_cnt;

    always_comb begin
        pop       = bus.fifo_read_ack & head_valid_q;
        unf_set   = bus.fifo_read_ack & ~head_valid_q;
        full      = (usedw_q == DEPTH_W);
        // Acceptance depends on real space, not on ready: a source that
        // ignores ready still gets in until the storage is truly full.
        wr_en     = bus.avl_st_in_valid & (~full | pop);
        ovf_set   = bus.avl_st_in_valid & full & ~pop;
        wr_eop    = wr_en & bus.avl_st_in_endofpacket;
        pop_eop   = pop & head_q[MW-1];

        // Words sitting in RAM behind the head register. A word written this
        // cycle is not counted yet, so the RAM is never read at an address
        // that is being written in the same cycle.
        mem_cnt   = usedw_q - {{AW{1'b0}}, head_valid_q};
        head_load = (mem_cnt != '0) & (~head_valid_q | pop);

        head_valid_d = head_load | (head_valid_q & ~pop);
        wr_ptr_d     = wr_en ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d     = head_load ? rd_ptr_q + PTR_ONE : rd_ptr_q;

        usedw_d = usedw_q;
        if (wr_en && !pop) begin
            usedw_d = usedw_q + CNT_ONE;
        end else if (!wr_en && pop) begin
            usedw_d = usedw_q - CNT_ONE;
        end

        lines_d = lines_q;
        if (wr_eop && !pop_eop) begin
            lines_d = lines_q + CNT_ONE;
        end else if (!wr_eop && pop_eop) begin
            lines_d = lines_q - CNT_ONE;
        end
    end

    // Storage array without reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= {bus.avl_st_in_endofpacket,
                              bus.avl_st_in_startofpacket,
                              bus.avl_st_in_data};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            usedw_q      <= '0;
            lines_q      <= '0;
            head_valid_q <= 1'b0;
            head_q       <= '0;
            ready_q      <= 1'b0;
            line_ready_q <= 1'b0;
            ovf_q        <= 1'b0;
            unf_q        <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            usedw_q      <= usedw_d;
            lines_q      <= lines_d;
            head_valid_q <= head_valid_d;
            if (head_load) begin
                head_q <= mem[rd_ptr_q];
            end
            ready_q      <= (usedw_d < READY_LIMIT);
            line_ready_q <= (lines_q != '0) || (int'(usedw_q) >= THR_WORDS);
            // Set has priority over clear so no event is lost.
            if (ovf_set) begin
                ovf_q <= 1'b1;
            end else if (bus.err_clear) begin
                ovf_q <= 1'b0;
            end
            if (unf_set) begin
                unf_q <= 1'b1;
            end else if (bus.err_clear) begin
                unf_q <= 1'b0;
            end
        end
    end

    assign bus.avl_st_in_ready = ready_q;
    assign bus.fifo_data       = head_q[DATA_WIDTH-1:0];
    assign bus.fifo_sop        = head_q[MW-2];
    assign bus.fifo_eop        = head_q[MW-1];
    assign bus.fifo_not_empty  = head_valid_q;
    assign bus.fifo_line_ready = line_ready_q;
    assign bus.fifo_usedw      = usedw_q;
    assign bus.lines_stored    = lines_q;
    assign bus.overflow_err    = ovf_q;
    assign bus.underflow_err   = unf_q;

`ifdef DSI_TX_LINE_BUF_STATS_EN
    logic [AW:0] max_usedw_q;
    logic [31:0] lines_total_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            max_usedw_q   <= '0;
            lines_total_q <= '0;
        end else begin
            if (bus.err_clear) begin
                max_usedw_q <= '0;
            end else if (usedw_q > max_usedw_q) begin
                max_usedw_q <= usedw_q;
            end
            if (pop_eop) begin
                lines_total_q <= lines_total_q + 32'd1;
            end
        end
    end

    assign bus.stat_max_usedw   = max_usedw_q;
    assign bus.stat_lines_total = lines_total_q;
`else
    assign bus.stat_max_usedw   = '0;
    assign bus.stat_lines_total = '0;
`endif

endmodule

// File: tb/tb_dsi_tx_line_buffer.sv
module tb_dsi_tx_line_buffer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dsi_tx_line_buffer_if #(.DATA_WIDTH(32), .FIFO_DEPTH(1024)) b1 ();
    dsi_tx_line_buffer_if #(.DATA_WIDTH(16), .FIFO_DEPTH(16))   b2 ();

    dsi_tx_line_buffer #(
        .DATA_WIDTH(32), .FIFO_DEPTH(1024), .LINE_THRESHOLD(640), .FULL_MARGIN(64)
    ) u_big (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b1)
    );

    dsi_tx_line_buffer #(
        .DATA_WIDTH(16), .FIFO_DEPTH(16), .LINE_THRESHOLD(16), .FULL_MARGIN(4)
    ) u_small (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b2)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        b1.avl_st_in_data = '0; b1.avl_st_in_valid = 1'b0;
        b1.avl_st_in_startofpacket = 1'b0; b1.avl_st_in_endofpacket = 1'b0;
        b1.fifo_read_ack = 1'b0; b1.err_clear = 1'b0;
        b2.avl_st_in_data = '0; b2.avl_st_in_valid = 1'b0;
        b2.avl_st_in_startofpacket = 1'b0; b2.avl_st_in_endofpacket = 1'b0;
        b2.fifo_read_ack = 1'b0; b2.err_clear = 1'b0;
    endtask

    typedef struct {
        logic        valid;
        logic        sop;
        logic        eop;
        logic [15:0] data;
        logic        ack;
        logic        clr;
        logic        e_ne;
        logic [15:0] e_data;
        logic        e_sop;
        logic        e_eop;
        logic [4:0]  e_used;
        logic [4:0]  e_lines;
        logic        e_lr;
        logic        e_rdy;
        logic        e_unf;
    } vec_t;

    vec_t vec [12];

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int n;
        // valid sop eop data ack clr | ne data sop eop used lines lr rdy unf
        vec[0]  = '{1'b1, 1'b1, 1'b0, 16'h1111, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 5'd1, 5'd0, 1'b0, 1'b1, 1'b0};
        vec[1]  = '{1'b1, 1'b0, 1'b1, 16'h2222, 1'b0, 1'b0, 1'b1, 16'h1111, 1'b1, 1'b0, 5'd2, 5'd1, 1'b0, 1'b1, 1'b0};
        vec[2]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h1111, 1'b1, 1'b0, 5'd2, 5'd1, 1'b1, 1'b1, 1'b0};
        vec[3]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h2222, 1'b0, 1'b1, 5'd1, 5'd1, 1'b1, 1'b1, 1'b0};
        vec[4]  = '{1'b1, 1'b1, 1'b1, 16'h3333, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 5'd1, 5'd1, 1'b1, 1'b1, 1'b0};
        vec[5]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h3333, 1'b1, 1'b1, 5'd1, 5'd1, 1'b1, 1'b1, 1'b0};
        vec[6]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0};
        vec[7]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0};
        vec[8]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1};
        vec[9]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0};
        vec[10] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1};
        vec[11] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0};

        idle_all();
        rst_n = 1'b0;

        // ---------------- reset and idle ----------------
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready",      b1.avl_st_in_ready, 0);
        chk("rst_not_empty",  b1.fifo_not_empty, 0);
        chk("rst_usedw",      b1.fifo_usedw, 0);
        chk("rst_lines",      b1.lines_stored, 0);
        chk("rst_line_ready", b1.fifo_line_ready, 0);
        chk("rst_ovf",        b1.overflow_err, 0);
        chk("rst_unf",        b1.underflow_err, 0);
        chk("rst_data",       b1.fifo_data, 0);
        chk("rst_stat_max",   b1.stat_max_usedw, 0);
        chk("rst_stat_tot",   b1.stat_lines_total, 0);
        chk("rst_ready_s",    b2.avl_st_in_ready, 0);
        rst_n = 1'b1;
        step();
        chk("ready_after_rst",   b1.avl_st_in_ready, 1);
        chk("ready_after_rst_s", b2.avl_st_in_ready, 1);
        chk("ne_after_rst",      b1.fifo_not_empty, 0);

        // ---------------- single word ----------------
        b1.avl_st_in_data = 32'hA5A5_0001;
        b1.avl_st_in_valid = 1'b1;
        b1.avl_st_in_startofpacket = 1'b1;
        b1.avl_st_in_endofpacket = 1'b1;
        step();
        idle_all();
        chk("sw_ne_k",    b1.fifo_not_empty, 0);
        chk("sw_used_k",  b1.fifo_usedw, 1);
        chk("sw_lines_k", b1.lines_stored, 1);
        chk("sw_lr_k",    b1.fifo_line_ready, 0);
        step();
        chk("sw_ne",   b1.fifo_not_empty, 1);
        chk("sw_data", b1.fifo_data, 32'hA5A5_0001);
        chk("sw_sop",  b1.fifo_sop, 1);
        chk("sw_eop",  b1.fifo_eop, 1);
        chk("sw_lr",   b1.fifo_line_ready, 1);
        b1.fifo_read_ack = 1'b1;
        step();
        b1.fifo_read_ack = 1'b0;
        chk("sw_pop_ne",    b1.fifo_not_empty, 0);
        chk("sw_pop_lines", b1.lines_stored, 0);
        chk("sw_pop_used",  b1.fifo_usedw, 0);
        chk("sw_pop_unf",   b1.underflow_err, 0);
        step();
        chk("sw_lr_drop", b1.fifo_line_ready, 0);

        // ---------------- threshold without EOP ----------------
        for (int i = 0; i < 159; i++) begin
            b1.avl_st_in_data = 32'(i);
            b1.avl_st_in_valid = 1'b1;
            b1.avl_st_in_startofpacket = (i == 0);
            step();
        end
        b1.avl_st_in_valid = 1'b0;
        b1.avl_st_in_startofpacket = 1'b0;
        step();
        chk("thr_used_159", b1.fifo_usedw, 159);
        chk("thr_lr_159",   b1.fifo_line_ready, 0);
        b1.avl_st_in_data = 32'd159;
        b1.avl_st_in_valid = 1'b1;
        step();
        b1.avl_st_in_valid = 1'b0;
        chk("thr_used_160",   b1.fifo_usedw, 160);
        chk("thr_lr_same",    b1.fifo_line_ready, 0);
        step();
        chk("thr_lr_next",    b1.fifo_line_ready, 1);
        chk("thr_lines_zero", b1.lines_stored, 0);

        // ---------------- backpressure (source honours ready) ----------------
        n = 160;
        for (int c = 0; c < 2000 && b1.fifo_usedw < 960; c++) begin
            if (b1.fifo_usedw == 959) chk("bp_ready_at_959", b1.avl_st_in_ready, 1);
            b1.avl_st_in_valid = b1.avl_st_in_ready;
            b1.avl_st_in_data = 32'(n);
            step();
            if (b1.avl_st_in_valid) n++;
        end
        chk("bp_used_960",  b1.fifo_usedw, 960);
        chk("bp_ready_low", b1.avl_st_in_ready, 0);
        for (int c = 0; c < 10; c++) begin
            b1.avl_st_in_valid = b1.avl_st_in_ready;
            step();
        end
        b1.avl_st_in_valid = 1'b0;
        chk("bp_used_hold",  b1.fifo_usedw, 960);
        chk("bp_ready_hold", b1.avl_st_in_ready, 0);
        chk("bp_no_ovf",     b1.overflow_err, 0);

        // ---------------- overflow (source ignores ready) ----------------
        for (int i = 0; i < 64; i++) begin
            b1.avl_st_in_valid = 1'b1;
            b1.avl_st_in_data = 32'(n);
            n++;
            step();
        end
        chk("ovf_used_full", b1.fifo_usedw, 1024);
        chk("ovf_not_yet",   b1.overflow_err, 0);
        b1.avl_st_in_data = 32'hDEAD_BEEF;
        step();
        chk("ovf_set",        b1.overflow_err, 1);
        chk("ovf_used_same",  b1.fifo_usedw, 1024);
        chk("ovf_lines_same", b1.lines_stored, 0);
        // write + read at full is accepted, not an overflow
        b1.avl_st_in_data = 32'(n);
        b1.fifo_read_ack = 1'b1;
        step();
        b1.avl_st_in_valid = 1'b0;
        b1.fifo_read_ack = 1'b0;
        chk("full_rw_used", b1.fifo_usedw, 1024);
        chk("full_rw_head", b1.fifo_data, 1);
        b1.err_clear = 1'b1;
        step();
        b1.err_clear = 1'b0;
        chk("ovf_cleared", b1.overflow_err, 0);
        // drain: expect 1..1024 in order, dropped word absent
        for (int e = 1; e <= 1024; e++) begin
            if (b1.fifo_not_empty !== 1'b1 || b1.fifo_data !== 32'(e)) begin
                chk("drain_word", {b1.fifo_not_empty, b1.fifo_data}, {1'b1, 32'(e)});
            end else begin
                checks++;
            end
            b1.fifo_read_ack = 1'b1;
            step();
        end
        b1.fifo_read_ack = 1'b0;
        chk("drain_used", b1.fifo_usedw, 0);
        chk("drain_ne",   b1.fifo_not_empty, 0);
        chk("drain_unf",  b1.underflow_err, 0);

        // ---------------- table: small buffer single-cycle ops ----------------
        for (int r = 0; r < 12; r++) begin
            b2.avl_st_in_valid = vec[r].valid;
            b2.avl_st_in_startofpacket = vec[r].sop;
            b2.avl_st_in_endofpacket = vec[r].eop;
            b2.avl_st_in_data = vec[r].data;
            b2.fifo_read_ack = vec[r].ack;
            b2.err_clear = vec[r].clr;
            step();
            chk($sformatf("vec%0d_ne", r),    b2.fifo_not_empty, vec[r].e_ne);
            if (vec[r].e_ne) begin
                chk($sformatf("vec%0d_data", r), b2.fifo_data, vec[r].e_data);
                chk($sformatf("vec%0d_sop", r),  b2.fifo_sop, vec[r].e_sop);
                chk($sformatf("vec%0d_eop", r),  b2.fifo_eop, vec[r].e_eop);
            end
            chk($sformatf("vec%0d_used", r),  b2.fifo_usedw, vec[r].e_used);
            chk($sformatf("vec%0d_lines", r), b2.lines_stored, vec[r].e_lines);
            chk($sformatf("vec%0d_lr", r),    b2.fifo_line_ready, vec[r].e_lr);
            chk($sformatf("vec%0d_rdy", r),   b2.avl_st_in_ready, vec[r].e_rdy);
            chk($sformatf("vec%0d_unf", r),   b2.underflow_err, vec[r].e_unf);
        end
        idle_all();

        // ---------------- streaming across wraps (depth 16) ----------------
        for (int i = 0; i < 5; i++) begin
            b2.avl_st_in_valid = 1'b1;
            b2.avl_st_in_data = 16'h5000 + 16'(i);
            step();
        end
        b2.avl_st_in_valid = 1'b0;
        step();
        chk("str_prime_used", b2.fifo_usedw, 5);
        for (int k = 0; k < 100; k++) begin
            chk("str_head", {b2.fifo_not_empty, b2.fifo_data}, {1'b1, 16'h5000 + 16'(k)});
            b2.avl_st_in_valid = 1'b1;
            b2.avl_st_in_data = 16'h5000 + 16'(k + 5);
            b2.fifo_read_ack = 1'b1;
            step();
            chk("str_used", b2.fifo_usedw, 5);
        end
        idle_all();
        step();
        chk("str_tail_head", b2.fifo_data, 16'h5000 + 16'd100);
        chk("str_no_unf",    b2.underflow_err, 0);
        chk("str_no_ovf",    b2.overflow_err, 0);

        // ---------------- statistics ----------------
`ifdef DSI_TX_LINE_BUF_STATS_EN
        chk("stat_max_small",   b2.stat_max_usedw, 5);
        chk("stat_total_small", b2.stat_lines_total, 2);
        chk("stat_max_big",     b1.stat_max_usedw, 1024);
        chk("stat_total_big",   b1.stat_lines_total, 1);
`else
        chk("stat_max_small",   b2.stat_max_usedw, 0);
        chk("stat_total_small", b2.stat_lines_total, 0);
        chk("stat_max_big",     b1.stat_max_usedw, 0);
        chk("stat_total_big",   b1.stat_lines_total, 0);
`endif

        // ---------------- asynchronous reset mid-transfer ----------------
        b2.avl_st_in_valid = 1'b1;
        b2.avl_st_in_data = 16'h7777;
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_used", b2.fifo_usedw, 0);
        chk("arst_ne",   b2.fifo_not_empty, 0);
        chk("arst_rdy",  b2.avl_st_in_ready, 0);
        idle_all();
        step();
        rst_n = 1'b1;
        step();
        chk("arst_rdy_back", b2.avl_st_in_ready, 1);
        chk("arst_used_back", b2.fifo_usedw, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
